sram16_device: RTL and testbench

Device-side responder for the arbitrated memory-device port: accepts one 32-bit read or write from the device arbiter and executes it as two back-to-back 16-bit accesses on an external asynchronous SRAM with a programmable number of wait cycles. It asserts busy for the whole transaction and returns exactly one in-order, single-cycle ack with data per accepted read. It sits between the arbiter's device port and the top-level SRAM pads; tristate muxing is done at the top level.

---
 rtl/sram16_device_pkg.sv | 31 +++
 rtl/sram16_device_if.sv | 32 +++
 rtl/sram16_device.sv | 131 +++++++++++++
 tb/tb_sram16_device.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram16_device_pkg.sv
// Shared types and widths for the 32-bit to 2x16-bit async SRAM responder.
package sram16_device_pkg;

  localparam int unsigned HOST_ADDR_W = 26;
  localparam int unsigned HOST_DATA_W = 32;
  localparam int unsigned WORD_ADDR_W = HOST_ADDR_W - 2;
  localparam int unsigned SRAM_ADDR_W = 25;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned WAIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Latched transaction; only the low write half is needed after acceptance.
  typedef struct packed {
    logic                   write;
    logic [WORD_ADDR_W-1:0] word_addr;
    logic [SRAM_DATA_W-1:0] data_lo;
  } dev_req_t;

  // Halfword pad address: half 0 is the big-endian upper half of the word.
  function automatic logic [SRAM_ADDR_W-1:0] half_addr(input logic [WORD_ADDR_W-1:0] word_addr,
                                                       input logic                   half);
    return {word_addr, half};
  endfunction

endpackage

// File: rtl/sram16_device_if.sv
// Arbiter device port plus SRAM pad-side signals of the sram16 responder.
interface sram16_device_if;
  import sram16_device_pkg::*;

  logic                   i_request;
  logic                   i_write;
  logic                   o_busy;
  logic                   o_ack;
  logic [HOST_ADDR_W-1:0] i_address;
  logic [HOST_DATA_W-1:0] i_data;
  logic [HOST_DATA_W-1:0] o_data;
  logic [SRAM_ADDR_W-1:0] o_sram_addr;
  logic [SRAM_DATA_W-1:0] o_sram_dq;
  logic [SRAM_DATA_W-1:0] i_sram_dq;
  logic                   o_sram_dq_oe;
  logic                   o_sram_ce_n;
  logic                   o_sram_oe_n;
  logic                   o_sram_we_n;

  modport slave (
    input  i_request, i_write, i_address, i_data, i_sram_dq,
    output o_busy, o_ack, o_data, o_sram_addr, o_sram_dq,
           o_sram_dq_oe, o_sram_ce_n, o_sram_oe_n, o_sram_we_n
  );

  modport master (
    output i_request, i_write, i_address, i_data, i_sram_dq,
    input  o_busy, o_ack, o_data, o_sram_addr, o_sram_dq,
           o_sram_dq_oe, o_sram_ce_n, o_sram_oe_n, o_sram_we_n
  );

endinterface

// File: rtl/sram16_device.sv
// Executes one 32-bit device access as two wait-stretched 16-bit async SRAM cycles.
module sram16_device
  import sram16_device_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            i_clk,
  input logic            i_reset_n,
  sram16_device_if.slave bus
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

  state_e                 r_state;
  dev_req_t               r_req;
  logic                   r_half;
  logic [WAIT_CNT_W-1:0]  r_cnt;
  logic [SRAM_DATA_W-1:0] r_rd_hi;
  logic                   r_busy;
  logic                   r_ack;
  logic [HOST_DATA_W-1:0] r_data;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [SRAM_DATA_W-1:0] r_sram_dq;
  logic                   r_dq_oe;
  logic                   r_ce_n;
  logic                   r_oe_n;
  logic                   r_we_n;

  logic w_cnt_zero;
  logic w_unused;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_unused   = ^bus.i_address[1:0];

  // Controller: every pad strobe is set on the same edge as the state it belongs to.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_half      <= 1'b0;
      r_cnt       <= '0;
      r_rd_hi     <= '0;
      r_busy      <= 1'b0;
      r_ack       <= 1'b0;
      r_data      <= '0;
      r_sram_addr <= '0;
      r_sram_dq   <= '0;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_request) begin
            r_req.write     <= bus.i_write;
            r_req.word_addr <= bus.i_address[HOST_ADDR_W-1:2];
            r_req.data_lo   <= bus.i_data[SRAM_DATA_W-1:0];
            r_half          <= 1'b0;
            r_cnt           <= WAIT_LOAD;
            r_state         <= ACCESS;
            r_busy          <= 1'b1;
            r_sram_addr     <= half_addr(bus.i_address[HOST_ADDR_W-1:2], 1'b0);
            r_ce_n          <= 1'b0;
            r_oe_n          <= bus.i_write;
            r_we_n          <= ~bus.i_write;
            r_dq_oe         <= bus.i_write;
            if (bus.i_write) begin
              r_sram_dq <= bus.i_data[HOST_DATA_W-1:SRAM_DATA_W];
            end
          end
        end
        ACCESS: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - WAIT_CNT_W'(1);
          end else if (r_req.write) begin
            r_state <= HOLD;
            r_we_n  <= 1'b1;
          end else if (!r_half) begin
            r_rd_hi     <= bus.i_sram_dq;
            r_half      <= 1'b1;
            r_cnt       <= WAIT_LOAD;
            r_sram_addr <= half_addr(r_req.word_addr, 1'b1);
          end else begin
            r_data  <= {r_rd_hi, bus.i_sram_dq};
            r_ack   <= 1'b1;
            r_state <= DONE;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
          end
        end
        HOLD: begin
          // One cycle with we_n high so each halfword write closes cleanly.
          if (!r_half) begin
            r_half      <= 1'b1;
            r_cnt       <= WAIT_LOAD;
            r_state     <= ACCESS;
            r_we_n      <= 1'b0;
            r_sram_addr <= half_addr(r_req.word_addr, 1'b1);
            r_sram_dq   <= r_req.data_lo;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ce_n  <= 1'b1;
            r_dq_oe <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy       = r_busy;
  assign bus.o_ack        = r_ack;
  assign bus.o_data       = r_data;
  assign bus.o_sram_addr  = r_sram_addr;
  assign bus.o_sram_dq    = r_sram_dq;
  assign bus.o_sram_dq_oe = r_dq_oe;
  assign bus.o_sram_ce_n  = r_ce_n;
  assign bus.o_sram_oe_n  = r_oe_n;
  assign bus.o_sram_we_n  = r_we_n;

endmodule

// File: tb/tb_sram16_device.sv
// Bench for sram16_device: W=2 and W=0 instances, each on an emulated async SRAM.
module tb_sram16_device;

  logic clk;
  logic rst_n;

  sram16_device_if ifa ();
  sram16_device_if ifb ();

  sram16_device #(.WAIT_CYCLES(2)) dut_a (.i_clk(clk), .i_reset_n(rst_n), .bus(ifa.slave));
  sram16_device #(.WAIT_CYCLES(0)) dut_b (.i_clk(clk), .i_reset_n(rst_n), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;

  logic        req   [2];
  logic        wr    [2];
  logic [25:0] addr  [2];
  logic [31:0] wdata [2];

  wire        busy  [2];
  wire        ack   [2];
  wire [31:0] odata [2];
  wire [24:0] saddr [2];
  wire [15:0] sdq   [2];
  wire        dq_oe [2];
  wire        ce_n  [2];
  wire        oe_n  [2];
  wire        we_n  [2];

  // Pad-side SRAM images and word-level reference memories
  logic [15:0] sram  [2][256];
  logic [31:0] ref_w [2][128];
  logic [31:0] last_rd [2];

  assign ifa.i_request = req[0];
  assign ifa.i_write   = wr[0];
  assign ifa.i_address = addr[0];
  assign ifa.i_data    = wdata[0];
  assign ifb.i_request = req[1];
  assign ifb.i_write   = wr[1];
  assign ifb.i_address = addr[1];
  assign ifb.i_data    = wdata[1];

  assign busy[0] = ifa.o_busy;       assign busy[1] = ifb.o_busy;
  assign ack[0]  = ifa.o_ack;        assign ack[1]  = ifb.o_ack;
  assign odata[0] = ifa.o_data;      assign odata[1] = ifb.o_data;
  assign saddr[0] = ifa.o_sram_addr; assign saddr[1] = ifb.o_sram_addr;
  assign sdq[0]   = ifa.o_sram_dq;   assign sdq[1]   = ifb.o_sram_dq;
  assign dq_oe[0] = ifa.o_sram_dq_oe; assign dq_oe[1] = ifb.o_sram_dq_oe;
  assign ce_n[0]  = ifa.o_sram_ce_n; assign ce_n[1]  = ifb.o_sram_ce_n;
  assign oe_n[0]  = ifa.o_sram_oe_n; assign oe_n[1]  = ifb.o_sram_oe_n;
  assign we_n[0]  = ifa.o_sram_we_n; assign we_n[1]  = ifb.o_sram_we_n;

  // Async SRAM: reads are combinational while selected, writes land on we_n rising
  assign ifa.i_sram_dq = (!ifa.o_sram_ce_n && !ifa.o_sram_oe_n) ? sram[0][ifa.o_sram_addr[7:0]] : 16'hDEAD;
  assign ifb.i_sram_dq = (!ifb.o_sram_ce_n && !ifb.o_sram_oe_n) ? sram[1][ifb.o_sram_addr[7:0]] : 16'hDEAD;

  always @(posedge ifa.o_sram_we_n)
    if (ifa.o_sram_ce_n === 1'b0) sram[0][ifa.o_sram_addr[7:0]] = ifa.o_sram_dq;
  always @(posedge ifb.o_sram_we_n)
    if (ifb.o_sram_ce_n === 1'b0) sram[1][ifb.o_sram_addr[7:0]] = ifb.o_sram_dq;

  always #5 clk = ~clk;

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input int d, input string tag);
    chk({tag, "_busy"},  32'(busy[d]),  32'd0);
    chk({tag, "_ack"},   32'(ack[d]),   32'd0);
    chk({tag, "_data"},  odata[d],      32'd0);
    chk({tag, "_addr"},  32'(saddr[d]), 32'd0);
    chk({tag, "_dq"},    32'(sdq[d]),   32'd0);
    chk({tag, "_dq_oe"}, 32'(dq_oe[d]), 32'd0);
    chk({tag, "_ce_n"},  32'(ce_n[d]),  32'd1);
    chk({tag, "_oe_n"},  32'(oe_n[d]),  32'd1);
    chk({tag, "_we_n"},  32'(we_n[d]),  32'd1);
  endtask

  // One isolated transaction; the reference is the word memory plus the timing rules.
  task automatic run_op(input int d, input bit wr_op, input logic [25:0] a, input logic [31:0] wd);
    int w, busy_n, ack_n, ack_k, we_low;
    logic [31:0] rdata, exp_word;
    logic [24:0] hw0;
    w = wait_of(d);
    busy_n = 0; ack_n = 0; ack_k = -1; we_low = 0; rdata = '0;
    hw0 = {a[25:2], 1'b0};
    exp_word = ref_w[d][a[8:2]];
    req[d] = 1'b1; wr[d] = wr_op; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    @(negedge clk);
    req[d] = 1'b0;
    for (int k = 0; k < 2*w + 8; k++) begin
      if (busy[d]) busy_n++;
      if (ack[d]) begin ack_n++; ack_k = k; rdata = odata[d]; end
      if (!we_n[d]) we_low++;
      if (k == 0) begin
        chk("first_ce_n",  32'(ce_n[d]),  32'd0);
        chk("first_addr",  32'(saddr[d]), 32'(hw0));
        chk("first_we_n",  32'(we_n[d]),  32'(!wr_op));
        chk("first_oe_n",  32'(oe_n[d]),  32'(wr_op));
        chk("first_dq_oe", 32'(dq_oe[d]), 32'(wr_op));
        if (wr_op) chk("first_dq", 32'(sdq[d]), 32'(wd[31:16]));
      end
      if (k == w + 1) begin
        if (wr_op) begin
          chk("hold_we_n",  32'(we_n[d]),  32'd1);
          chk("hold_ce_n",  32'(ce_n[d]),  32'd0);
          chk("hold_dq_oe", 32'(dq_oe[d]), 32'd1);
          chk("hold_addr",  32'(saddr[d]), 32'(hw0));
        end else begin
          chk("rd_half1_addr", 32'(saddr[d]), 32'(hw0) + 32'd1);
        end
      end
      if (wr_op && k == w + 2) begin
        chk("wr_half1_addr", 32'(saddr[d]), 32'(hw0) + 32'd1);
        chk("wr_half1_dq",   32'(sdq[d]),   32'(wd[15:0]));
        chk("wr_half1_we_n", 32'(we_n[d]),  32'd0);
      end
      @(negedge clk);
    end
    if (wr_op) begin
      ref_w[d][a[8:2]] = wd;
      chk("wr_busy_cycles", 32'(busy_n), 32'(2*w + 4));
      chk("wr_no_ack",      32'(ack_n),  32'd0);
      chk("wr_we_low",      32'(we_low), 32'(2*w + 2));
      chk("wr_pad_hi",      32'(sram[d][{a[8:2], 1'b0}]), 32'(wd[31:16]));
      chk("wr_pad_lo",      32'(sram[d][{a[8:2], 1'b1}]), 32'(wd[15:0]));
      chk("wr_data_held",   odata[d], last_rd[d]);
    end else begin
      last_rd[d] = exp_word;
      chk("rd_busy_cycles", 32'(busy_n), 32'(2*w + 3));
      chk("rd_ack_count",   32'(ack_n),  32'd1);
      chk("rd_ack_cycle",   32'(ack_k),  32'(2*w + 2));
      chk("rd_data",        rdata,       exp_word);
      chk("rd_data_held",   odata[d],    exp_word);
    end
  endtask

  // First op, then a read held on i_request while busy; the read starts at the first idle edge.
  task automatic held_pair(input int d, input bit wr1, input logic [25:0] a1,
                           input logic [31:0] d1, input logic [25:0] a2);
    int w, l1, re_k, ack_n, ack1_k, ack2_k;
    logic [31:0] exp1, exp2, dat1, dat2;
    bit prev;
    w = wait_of(d);
    l1 = wr1 ? 2*w + 4 : 2*w + 3;
    exp1 = ref_w[d][a1[8:2]];
    if (wr1) ref_w[d][a1[8:2]] = d1;
    exp2 = ref_w[d][a2[8:2]];
    re_k = -1; ack_n = 0; ack1_k = -1; ack2_k = -1; dat1 = '0; dat2 = '0; prev = 1'b1;
    req[d] = 1'b1; wr[d] = wr1; addr[d] = a1; wdata[d] = d1;
    @(posedge clk);
    @(negedge clk);
    wr[d] = 1'b0; addr[d] = a2; wdata[d] = $urandom;
    for (int k = 0; k < l1 + 2*w + 8; k++) begin
      if (busy[d] && !prev && re_k < 0) begin re_k = k; req[d] = 1'b0; end
      if (ack[d]) begin
        ack_n++;
        if (re_k < 0) begin ack1_k = k; dat1 = odata[d]; end
        else begin ack2_k = k; dat2 = odata[d]; end
      end
      prev = busy[d];
      @(negedge clk);
    end
    req[d] = 1'b0;
    last_rd[d] = exp2;
    chk("held_accept_cycle", 32'(re_k),   32'(l1 + 1));
    chk("held_ack_count",    32'(ack_n),  wr1 ? 32'd1 : 32'd2);
    chk("held_ack2_cycle",   32'(ack2_k), 32'(l1 + 2*w + 3));
    chk("held_ack2_data",    dat2,        exp2);
    if (!wr1) begin
      chk("held_ack1_cycle", 32'(ack1_k), 32'(2*w + 2));
      chk("held_ack1_data",  dat1,        exp1);
    end
  endtask

  initial begin
    int ack_n, busy_n;
    logic [31:0] word;
    clk = 1'b0;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0; last_rd[d] = '0;
      for (int i = 0; i < 128; i++) begin
        word = $urandom;
        ref_w[d][i] = word;
        sram[d][2*i]     = word[31:16];
        sram[d][2*i + 1] = word[15:0];
      end
    end
    ref_w[0][4] = 32'h12345678;
    sram[0][8]  = 16'h1234;
    sram[0][9]  = 16'h5678;

    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs(0, "rst_a");
    chk_reset_outputs(1, "rst_b");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 1'b0, 26'h0000010, 32'h0);
    run_op(0, 1'b1, 26'h0000020, 32'hCAFEBABE);
    held_pair(0, 1'b1, 26'h0000044, 32'hA5A51234, 26'h0000046);
    held_pair(1, 1'b0, 26'h0000003, 32'h0, 26'h0000007);

    for (int i = 0; i < 24; i++) begin
      run_op(i % 2, 1'($urandom_range(0, 1)), 26'($urandom_range(0, 511)), $urandom);
    end

    // Reset in the middle of a read: everything returns to idle at once, no late ack
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 26'h0000010;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs(0, "midrst");
    @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    ack_n = 0; busy_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack[0]) ack_n++;
      if (busy[0]) busy_n++;
    end
    chk("midrst_no_ack",  32'(ack_n),  32'd0);
    chk("midrst_no_busy", 32'(busy_n), 32'd0);
    run_op(0, 1'b0, 26'h0000010, 32'h0);
    run_op(1, 1'b0, 26'($urandom_range(0, 511)), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
